// File: rtl/layer1_neuron_mac.sv
// Fully-connected layer engine: one neuron at a time, LANES int8 MACs per cycle,
// requantized by an arithmetic shift and clamped to 0..127, with a valid/ready result port.
module layer1_neuron_mac #(
   parameter int N_NEURONS = 30,
   parameter int N_INPUTS  = 432,
   parameter int LANES     = 8,
   parameter int SHIFT     = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [N_INPUTS*8-1:0]   act_flat,
   output logic [4:0]              neuron_index,
   input  logic [N_INPUTS*8-1:0]   neuron_weights_flat,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4:0]              out_neuron,
   output logic [7:0]              out_data,
   output logic                    busy,
   output logic                    done
);

   localparam int N_CHUNKS = N_INPUTS / LANES;
   localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [CW-1:0] LAST_CHUNK  = CW'(N_CHUNKS - 1);
   localparam logic [4:0]    LAST_NEURON = 5'(N_NEURONS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_MAC,
      S_FINISH,
      S_OUT
   } state_t;

   state_t             state;
   logic [CW-1:0]      chunk;
   logic signed [31:0] acc;
   logic signed [31:0] chunk_sum;
   logic signed [31:0] shifted;
   logic [7:0]         sat_data;

   // Dot product of the current LANES-wide slice of activations and weights.
   always_comb begin
      logic signed [7:0]  a_l;
      logic signed [7:0]  w_l;
      logic signed [15:0] prod;
      int                 idx;
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      chunk_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         idx       = int'(chunk) * LANES + l;
         a_l       = act_flat[idx*8 +: 8];
         w_l       = neuron_weights_flat[idx*8 +: 8];
         prod      = a_l * w_l;
         chunk_sum = chunk_sum + {{16{prod[15]}}, prod};
      end
   end

   assign shifted = acc >>> SHIFT;

   always_comb begin
      sat_data = 8'd0;
      if (shifted < 0)
         sat_data = 8'd0;
      else if (shifted > 32'sd127)
         sat_data = 8'd127;
      else
         sat_data = shifted[7:0];
   end

   assign busy = (state != S_IDLE);

   // After the last handshake the FSM lingers one cycle in OUT with done high,
   // so a start coinciding with done is not seen in IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         neuron_index <= '0;
         acc          <= '0;
         chunk        <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_neuron   <= '0;
         done         <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  neuron_index <= '0;
                  acc          <= '0;
                  state        <= S_FETCH;
               end
            end
            S_FETCH: begin
               chunk <= '0;
               state <= S_MAC;
            end
            S_MAC: begin
               acc   <= acc + chunk_sum;
               chunk <= chunk + 1'b1;
               if (chunk == LAST_CHUNK)
                  state <= S_FINISH;
            end
            S_FINISH: begin
               out_data   <= sat_data;
               out_neuron <= neuron_index;
               out_valid  <= 1'b1;
               state      <= S_OUT;
            end
            S_OUT: begin
               if (done) begin
                  done  <= 1'b0;
                  state <= S_IDLE;
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (neuron_index < LAST_NEURON) begin
                     neuron_index <= neuron_index + 5'd1;
                     acc          <= '0;
                     state        <= S_FETCH;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/layer1_neuron_mac.md
LAYER1_NEURON_MAC -- requirements
Module: layer1_neuron_mac

Interface
REQ-001 SHALL have parameter N_NEURONS, default 30: neurons per layer.
REQ-002 SHALL have parameter N_INPUTS, default 432: weights/activations per neuron.
REQ-003 SHALL have parameter LANES, default 8: MACs per cycle; N_INPUTS divisible by LANES.
REQ-004 SHALL have parameter SHIFT, default 7: requantization right-shift.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset; synchronous, active-low.
REQ-007 SHALL have port start, input, 1: begin layer; sampled only in IDLE.
REQ-008 SHALL have port act_flat, input, N_INPUTS*8: signed int8 activations, element i at [8*i +: 8]; held stable while busy.
REQ-009 SHALL have port neuron_index, output, 5: registered neuron select to weight ROM.
REQ-010 SHALL have port neuron_weights_flat, input, N_INPUTS*8: signed int8 weights from ROM, element i at [8*i +: 8], valid one cycle after neuron_index changes.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port out_neuron, output, 5: index of current result.
REQ-014 SHALL have port out_data, output, 8: unsigned activation 0..127.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse after last result accepted.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, MAC, FINISH, OUT.
REQ-018 IDLE: start=1 -> neuron_index=0, acc=0, go to FETCH; otherwise stay in IDLE.
REQ-019 FETCH: one cycle (ROM latency); chunk counter=0; go to MAC.
REQ-020 MAC: each cycle, add sum over l<LANES of act[c*LANES+l]*w[c*LANES+l] (signed 8x8) into a 32-bit signed accumulator; c increments; after N_INPUTS/LANES cycles (54 by default) go to FINISH.
REQ-021 FINISH: compute r = acc >>> SHIFT (arithmetic); out_data = 0 if r<0, 127 if r>127, else r[7:0]; register out_data and out_neuron; go to OUT.
REQ-022 OUT: out_valid=1; out_data and out_neuron held stable until out_valid && out_ready is sampled.
REQ-023 On handshake: if neuron_index < N_NEURONS-1, increment neuron_index, clear acc, go to FETCH; otherwise assert done for one cycle and go to IDLE.
REQ-024 Timing: with start sampled at edge k, out_valid SHALL first be high after edge k+56; with out_ready held at 1, the per-neuron period SHALL be 57 cycles; a full layer SHALL take 1710 cycles.
REQ-025 start while busy SHALL be ignored; start in the same cycle done is high SHALL NOT be accepted (FSM is not yet in IDLE).
REQ-026 out_valid SHALL never deassert without a handshake, except on reset.
REQ-027 Accumulator SHALL not overflow: max |sum| = 432*128*128 < 2^31.

Reset
REQ-028 rst_n=0 at a clock edge SHALL set: state=IDLE, neuron_index=0, acc=0, chunk counter=0, out_valid=0, out_data=0, out_neuron=0, busy=0, done=0.
REQ-029 Reset asserted mid-MAC or mid-OUT SHALL abort the layer; no result is emitted for the aborted neuron, and a new start is required.

Verification
REQ-030 All act=1, all weights=1, out_ready=1, start pulse -> out_valid after edge k+56, out_data=3 (432>>7), out_neuron=0..29 in order, done one cycle after the 30th handshake.
REQ-031 All act=127, all weights=127 -> out_data=127 (saturated) for every neuron.
REQ-032 All act=1, all weights=-1 -> out_data=0 (ReLU).
REQ-033 out_ready=0 for 10 cycles during OUT -> out_valid stays 1, out_data and out_neuron unchanged, FSM stays in OUT, neuron_index unchanged.
REQ-034 rst_n=0 at MAC chunk 20 of neuron 5 -> all outputs at reset values next cycle; a later start restarts from neuron_index=0.
REQ-035 start pulsed at cycle 100 of the layer -> no effect: sequence and result count are unchanged, done pulses exactly once.
